vid_mode_ctrl: RTL and testbench
================================

VID_MODE_CTRL -- requirements
Module: vid_mode_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 8192: prescaler period in clk cycles; legal range is >= 2.
REQ-002 Parameter DEBOUNCE_TICKS, default 3: consecutive stable tick samples needed to accept a button press or release; legal range is >= 1.
REQ-003 Parameter NUM_MODES, default 10: number of legal video modes; legal range is 2..2**MODE_W.
REQ-004 Parameter MODE_W, default 4: mode field width.
REQ-005 Parameter RESET_MODE, default 0: mode after reset; legal range is < NUM_MODES.
REQ-006 Parameter CHG_HOLD, default 4: clk cycles that mode_change stays high; legal range is >= 1.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 Port btn_next_n, input, 1 bit: asynchronous active-low pushbutton that advances the mode.
REQ-010 Port btn_prev_n, input, 1 bit: asynchronous active-low pushbutton that steps the mode back.
REQ-011 Port load, input, 1 bit: synchronous one-cycle strobe that loads load_mode.
REQ-012 Port load_mode, input, MODE_W bits: mode value to load.
REQ-013 Port tick, output, 1 bit: prescaler strobe, one cycle wide.
REQ-014 Port heartbeat, output, 1 bit: square wave for an LED.
REQ-015 Port mode, output, MODE_W bits: current mode.
REQ-016 Port mode_change, output, 1 bit: high while a mode change is announced.
REQ-017 Port load_err, output, 1 bit: one-cycle pulse when load_mode is out of range.

Function
REQ-018 Each button SHALL pass through a 2-FF synchroniser before any use.
REQ-019 Prescaler SHALL count 0..CLK_DIV-1 and then wrap to 0.
REQ-020 tick SHALL be registered and high for exactly one cycle after each cycle in which the prescaler equals CLK_DIV-1; the first tick is at clk cycle CLK_DIV after reset release.
REQ-021 heartbeat SHALL be registered and toggle on every tick.
REQ-022 Per button, a debounce FSM SHALL sample the synchronised level only in tick cycles and hold its state in all other cycles:
  - IDLE: low sample -> PRESS_CNT with count=1.
  - PRESS_CNT: low sample -> count+1; high sample -> IDLE; count reaching DEBOUNCE_TICKS -> emit a one-cycle press event, go to HELD.
  - HELD: high sample -> REL_CNT with count=1.
  - REL_CNT: high sample -> count+1; low sample -> HELD; count reaching DEBOUNCE_TICKS -> IDLE.
REQ-023 Each physical press SHALL produce exactly one press event; a held button SHALL NOT auto-repeat.
REQ-024 With DEBOUNCE_TICKS=1, the press event SHALL fire on the first low tick sample.
REQ-025 A next press SHALL set mode to mode+1, or to 0 when mode = NUM_MODES-1.
REQ-026 A prev press SHALL set mode to mode-1, or to NUM_MODES-1 when mode = 0.
REQ-027 Next and prev press events in the same cycle SHALL cancel: mode unchanged, no mode_change.
REQ-028 load SHALL have priority over button events in the same cycle; the button events in that cycle are discarded.
REQ-029 load with load_mode < NUM_MODES SHALL set mode = load_mode on the next edge.
REQ-030 load with load_mode >= NUM_MODES SHALL leave mode unchanged and pulse load_err for one cycle, starting the cycle after load.
REQ-031 mode_change SHALL rise on the same edge that mode takes a new value and stay high for CHG_HOLD cycles.
REQ-032 An update that leaves mode at its old value (load of the current value, cancelled presses) SHALL NOT assert mode_change.
REQ-033 A new change during an active hold SHALL restart the hold count, keeping mode_change continuously high.
REQ-034 mode SHALL never hold a value >= NUM_MODES.
REQ-035 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-036 While rst=1, the block SHALL be in this state:
  - mode = RESET_MODE.
  - tick, heartbeat, mode_change, load_err = 0.
  - prescaler, hold and debounce counters = 0.
  - Both FSMs = IDLE.
  - Synchroniser flops = 1 (button released).
REQ-037 Assertion of rst mid-operation SHALL take effect immediately, asynchronously, and discard any press in progress.
REQ-038 Release of rst SHALL be followed by normal counting starting from 0.

Verification
REQ-039 The bench SHALL use CLK_DIV=4, DEBOUNCE_TICKS=2, NUM_MODES=3, CHG_HOLD=2, RESET_MODE=0 unless a scenario states otherwise, and SHALL cover these directed scenarios:
  - Release rst, idle 20 cycles -> tick high at cycles 4, 8, 12, 16, 20; heartbeat toggles at each; mode=0.
  - Hold btn_next_n low for 3 ticks, then release -> mode 0->1 once, mode_change high for 2 cycles; no second step while held.
  - Press next three times from mode 0 -> 1, 2, 0 (wrap); one prev press from 0 -> 2.
  - Button low for 1 tick only (glitch) -> no mode change.
  - load=1, load_mode=2 -> mode=2, mode_change high; load_mode=5 -> mode unchanged, load_err one pulse; load_mode = current mode -> no mode_change.
  - Next and prev events in the same cycle -> no change; assert rst mid-press -> mode=0, FSMs IDLE; after release, no spurious event until a new full press.

Source files
------------

// File: rtl/vid_mode_ctrl.sv
// Video mode controller: two debounced pushbuttons step a mode register up or
// down, a synchronous load strobe can set it directly, and a free-running
// prescaler supplies the debounce sample strobe and an LED heartbeat.

// Per-button front end: 2-FF synchroniser followed by a tick-sampled debounce
// FSM that emits exactly one press pulse per accepted physical press.
module vid_mode_db #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } db_state_t;

    // FSM state and its run-length counter, kept together so a checker can
    // bind to one signal and see the whole debounce state.
    typedef struct packed {
        db_state_t       state;
        logic [CW-1:0]   cnt;
    } db_dbg_t;

    logic    sync_1;
    logic    sync_2;
    db_dbg_t db_r;

    // Synchronise the asynchronous button; flops idle high (button released).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    // Debounce FSM: looks at sync_2 only in tick cycles, holds otherwise.
    // A press is accepted after DEBOUNCE_TICKS low samples and the button must
    // then read high for DEBOUNCE_TICKS samples before another press can count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_r.state <= IDLE;
            db_r.cnt   <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (tick) begin
                case (db_r.state)
                    IDLE: begin
                        if (!sync_2) begin
                            if (CNT_TOP == CNT_ONE) begin
                                press      <= 1'b1;
                                db_r.state <= HELD;
                                db_r.cnt   <= '0;
                            end else begin
                                db_r.state <= PRESS_CNT;
                                db_r.cnt   <= CNT_ONE;
                            end
                        end
                    end
                    PRESS_CNT: begin
                        if (sync_2) begin
                            db_r.state <= IDLE;
                            db_r.cnt   <= '0;
                        end else if (db_r.cnt + CNT_ONE == CNT_TOP) begin
                            press      <= 1'b1;
                            db_r.state <= HELD;
                            db_r.cnt   <= '0;
                        end else begin
                            db_r.cnt   <= db_r.cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (sync_2) begin
                            if (CNT_TOP == CNT_ONE) begin
                                db_r.state <= IDLE;
                                db_r.cnt   <= '0;
                            end else begin
                                db_r.state <= REL_CNT;
                                db_r.cnt   <= CNT_ONE;
                            end
                        end
                    end
                    REL_CNT: begin
                        if (!sync_2) begin
                            db_r.state <= HELD;
                            db_r.cnt   <= '0;
                        end else if (db_r.cnt + CNT_ONE == CNT_TOP) begin
                            db_r.state <= IDLE;
                            db_r.cnt   <= '0;
                        end else begin
                            db_r.cnt   <= db_r.cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        db_r.state <= IDLE;
                        db_r.cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

module vid_mode_ctrl #(
    parameter int CLK_DIV        = 8192,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int NUM_MODES      = 10,
    parameter int MODE_W         = 4,
    parameter int RESET_MODE     = 0,
    parameter int CHG_HOLD       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_next_n,
    input  logic              btn_prev_n,
    input  logic              load,
    input  logic [MODE_W-1:0] load_mode,
    output logic              tick,
    output logic              heartbeat,
    output logic [MODE_W-1:0] mode,
    output logic              mode_change,
    output logic              load_err
);

    // Parameter legality is checked while elaborating, never at run time.
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("vid_mode_ctrl: CLK_DIV must be >= 2");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("vid_mode_ctrl: DEBOUNCE_TICKS must be >= 1");
    end
    if (MODE_W < 1 || MODE_W > 30) begin : g_bad_mode_w
        $error("vid_mode_ctrl: MODE_W out of range");
    end
    if (NUM_MODES < 2 || NUM_MODES > (1 << MODE_W)) begin : g_bad_num_modes
        $error("vid_mode_ctrl: NUM_MODES must be in 2..2**MODE_W");
    end
    if (RESET_MODE < 0 || RESET_MODE >= NUM_MODES) begin : g_bad_reset_mode
        $error("vid_mode_ctrl: RESET_MODE must be < NUM_MODES");
    end
    if (CHG_HOLD < 1) begin : g_bad_chg_hold
        $error("vid_mode_ctrl: CHG_HOLD must be >= 1");
    end

    localparam int PW = $clog2(CLK_DIV);
    localparam int HW = $clog2(CHG_HOLD + 1);

    localparam logic [PW-1:0]     PRESC_TOP   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]     PRESC_ONE   = PW'(1);
    localparam logic [MODE_W:0]   NUM_MODES_W = (MODE_W + 1)'(NUM_MODES);
    localparam logic [MODE_W-1:0] MODE_MAX    = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_RST    = MODE_W'(RESET_MODE);
    localparam logic [MODE_W-1:0] MODE_ONE    = MODE_W'(1);
    localparam logic [HW-1:0]     HOLD_INIT   = HW'(CHG_HOLD - 1);
    localparam logic [HW-1:0]     HOLD_ONE    = HW'(1);

    logic [PW-1:0]     presc;
    logic [HW-1:0]     hold_cnt;
    logic              press_next;
    logic              press_prev;
    logic [MODE_W-1:0] mode_nxt;
    logic              load_bad;
    logic              mode_upd;

    // Free-running prescaler; tick and heartbeat are registered off its wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            tick      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            if (presc == PRESC_TOP) begin
                presc     <= '0;
                tick      <= 1'b1;
                heartbeat <= ~heartbeat;
            end else begin
                presc     <= presc + PRESC_ONE;
                tick      <= 1'b0;
            end
        end
    end

    vid_mode_db #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn_n (btn_next_n),
        .press (press_next)
    );

    vid_mode_db #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_prev (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn_n (btn_prev_n),
        .press (press_prev)
    );

    // Next-mode selection. load is a plain strobe with no ready: every load
    // cycle is consumed and wins over button events in that same cycle.
    // Opposing presses in one cycle cancel; every path keeps mode < NUM_MODES.
    always_comb begin
        mode_nxt = mode;
        load_bad = 1'b0;
        if (load) begin
            if ({1'b0, load_mode} < NUM_MODES_W) begin
                mode_nxt = load_mode;
            end else begin
                load_bad = 1'b1;
            end
        end else if (press_next && !press_prev) begin
            mode_nxt = (mode == MODE_MAX) ? '0 : mode + MODE_ONE;
        end else if (press_prev && !press_next) begin
            mode_nxt = (mode == '0) ? MODE_MAX : mode - MODE_ONE;
        end
        mode_upd = (mode_nxt != mode);
    end

    // Mode register plus the mode_change hold timer; a change during an
    // active hold reloads the timer so the flag stays continuously high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= MODE_RST;
            mode_change <= 1'b0;
            hold_cnt    <= '0;
            load_err    <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            load_err <= load_bad;
            if (mode_upd) begin
                mode_change <= 1'b1;
                hold_cnt    <= HOLD_INIT;
            end else if (hold_cnt != '0) begin
                hold_cnt    <= hold_cnt - HOLD_ONE;
            end else begin
                mode_change <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vid_mode_ctrl.sv
// Directed bench for vid_mode_ctrl with a small prescaler so button presses
// resolve in tens of cycles. Outputs are sampled 1 time unit after each
// rising edge; a background tally in cyc() tracks mode_change/load_err pulses.
module tb_vid_mode_ctrl;

    localparam int CLK_DIV        = 4;
    localparam int DEBOUNCE_TICKS = 2;
    localparam int NUM_MODES      = 3;
    localparam int MODE_W         = 4;
    localparam int RESET_MODE     = 0;
    localparam int CHG_HOLD       = 2;

    logic              clk;
    logic              rst;
    logic              btn_next_n;
    logic              btn_prev_n;
    logic              load;
    logic [MODE_W-1:0] load_mode;
    logic              tick;
    logic              heartbeat;
    logic [MODE_W-1:0] mode;
    logic              mode_change;
    logic              load_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int   chg_rises   = 0;
    int   err_rises   = 0;
    int   mc_len      = 0;
    int   err_len     = 0;
    logic mc_q        = 1'b0;
    logic err_q       = 1'b0;
    bit   hold_chk_en = 1'b1;

    vid_mode_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .NUM_MODES      (NUM_MODES),
        .MODE_W         (MODE_W),
        .RESET_MODE     (RESET_MODE),
        .CHG_HOLD       (CHG_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next_n  (btn_next_n),
        .btn_prev_n  (btn_prev_n),
        .load        (load),
        .load_mode   (load_mode),
        .tick        (tick),
        .heartbeat   (heartbeat),
        .mode        (mode),
        .mode_change (mode_change),
        .load_err    (load_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample and update the pulse tallies.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (mode_change && !mc_q) chg_rises++;
        if (load_err && !err_q) err_rises++;
        if (mode_change) begin
            mc_len++;
        end else if (mc_q) begin
            if (hold_chk_en) check("chg_hold_len", mc_len, CHG_HOLD);
            mc_len = 0;
        end
        if (load_err) begin
            err_len++;
        end else if (err_q) begin
            check("load_err_len", err_len, 1);
            err_len = 0;
        end
        mc_q  = mode_change;
        err_q = load_err;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Driver: hold the selected buttons low for a number of ticks, release,
    // then idle long enough for release debounce and the change hold to end.
    task automatic press(input bit nxt, input bit prv, input int ticks_low);
        chg_rises  = 0;
        btn_next_n = ~nxt;
        btn_prev_n = ~prv;
        run(ticks_low * CLK_DIV);
        btn_next_n = 1'b1;
        btn_prev_n = 1'b1;
        run(20);
    endtask

    initial begin
        rst        = 1'b1;
        btn_next_n = 1'b1;
        btn_prev_n = 1'b1;
        load       = 1'b0;
        load_mode  = '0;
        run(3);

        // Reset state
        check("rst_mode", mode, 0);
        check("rst_tick", tick, 0);
        check("rst_heartbeat", heartbeat, 0);
        check("rst_mode_change", mode_change, 0);
        check("rst_load_err", load_err, 0);

        // Idle after release: tick every 4th cycle, heartbeat toggles on it
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check("tick", tick, (k % 4 == 0) ? 1 : 0);
            check("heartbeat", heartbeat, (k / 4) % 2);
        end
        check("idle_mode", mode, 0);

        // Next held 3 ticks: single step 0 -> 1
        press(1'b1, 1'b0, 3);
        check("next_hold3_mode", mode, 1);
        check("next_hold3_rises", chg_rises, 1);

        // Load back to 0: applied on the next edge with mode_change
        load = 1'b1; load_mode = 4'd0;
        cyc();
        load = 1'b0;
        check("load0_mode", mode, 0);
        check("load0_chg", mode_change, 1);
        run(4);

        // Three next presses wrap 0 -> 1 -> 2 -> 0, then prev wraps 0 -> 2
        press(1'b1, 1'b0, 3);
        check("next_a_mode", mode, 1);
        press(1'b1, 1'b0, 3);
        check("next_b_mode", mode, 2);
        press(1'b1, 1'b0, 3);
        check("next_wrap_mode", mode, 0);
        check("next_wrap_rises", chg_rises, 1);
        press(1'b0, 1'b1, 3);
        check("prev_wrap_mode", mode, 2);
        check("prev_wrap_rises", chg_rises, 1);

        // One-tick glitch is rejected
        press(1'b0, 1'b1, 1);
        check("glitch_mode", mode, 2);
        check("glitch_rises", chg_rises, 0);

        // Long hold gives one step only, no auto-repeat
        press(1'b1, 1'b0, 8);
        check("long_hold_mode", mode, 0);
        check("long_hold_rises", chg_rises, 1);

        // Load legal value 2: exact CHG_HOLD window
        load = 1'b1; load_mode = 4'd2;
        cyc();
        load = 1'b0;
        check("load2_mode", mode, 2);
        check("load2_chg_c1", mode_change, 1);
        check("load2_err", load_err, 0);
        cyc();
        check("load2_chg_c2", mode_change, 1);
        cyc();
        check("load2_chg_c3", mode_change, 0);

        // Out-of-range loads: mode kept, one-cycle load_err
        load = 1'b1; load_mode = 4'd5;
        cyc();
        load = 1'b0;
        check("load5_mode", mode, 2);
        check("load5_err", load_err, 1);
        check("load5_chg", mode_change, 0);
        cyc();
        check("load5_err_end", load_err, 0);
        load = 1'b1; load_mode = 4'd3;
        cyc();
        load = 1'b0;
        check("load3_mode", mode, 2);
        check("load3_err", load_err, 1);
        cyc();
        check("load3_err_end", load_err, 0);

        // Load of the current value: no announcement
        load = 1'b1; load_mode = 4'd2;
        cyc();
        load = 1'b0;
        check("load_same_mode", mode, 2);
        check("load_same_chg", mode_change, 0);
        check("load_same_err", load_err, 0);
        cyc();
        check("load_same_chg2", mode_change, 0);

        // Back-to-back changes restart the hold: flag high for 3 cycles
        hold_chk_en = 1'b0;
        load = 1'b1; load_mode = 4'd0;
        cyc();
        load_mode = 4'd1;
        check("restart_mode_a", mode, 0);
        check("restart_chg_a", mode_change, 1);
        cyc();
        load = 1'b0;
        check("restart_mode_b", mode, 1);
        check("restart_chg_b", mode_change, 1);
        cyc();
        check("restart_chg_c", mode_change, 1);
        cyc();
        check("restart_chg_d", mode_change, 0);
        cyc();
        hold_chk_en = 1'b1;

        // Next and prev together cancel
        press(1'b1, 1'b1, 3);
        check("both_mode", mode, 1);
        check("both_rises", chg_rises, 0);

        // Asynchronous reset in the middle of a press
        btn_next_n = 1'b0;
        run(5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mode", mode, 0);
        check("arst_tick", tick, 0);
        check("arst_heartbeat", heartbeat, 0);
        check("arst_next_state", dut.u_db_next.db_r.state, 0);
        check("arst_next_cnt", dut.u_db_next.db_r.cnt, 0);
        check("arst_prev_state", dut.u_db_prev.db_r.state, 0);
        check("arst_next_sync", dut.u_db_next.sync_2, 1);
        btn_next_n = 1'b1;
        run(2);
        @(negedge clk);
        rst = 1'b0;
        chg_rises = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("post_rst_tick", tick, (k % 4 == 0) ? 1 : 0);
        end
        run(32);
        check("post_rst_mode", mode, 0);
        check("post_rst_rises", chg_rises, 0);

        // A fresh full press works normally
        press(1'b1, 1'b0, 3);
        check("fresh_mode", mode, 1);
        check("fresh_rises", chg_rises, 1);
        check("total_err_pulses", err_rises, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
